// File: rtl/p2_mem_pkg.sv
// Shared constants for the p2_mem wait-stated byte-lane memory block:
// FSM state encoding and default parameter values.
package p2_mem_pkg;

  // FSM state enumeration
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_HOLD   = 2'd3;

  localparam int DEF_DATA_W       = 16;
  localparam int DEF_ADDR_W       = 23;
  localparam int DEF_MEM_BYTES    = 524288;
  localparam int DEF_DECODE_LIMIT = 4194304;
  localparam int DEF_WAIT_CYCLES  = 2;

endpackage

// File: rtl/p2_mem_array.sv
// Byte-lane storage: NUM_LANES independent 8-bit RAMs, synchronous read,
// per-lane write enable. Contents are never reset.
module p2_mem_array #(
  parameter int NUM_LANES = 2,
  parameter int WORDS     = 262144,
  parameter int IDX_W     = $clog2(WORDS)
) (
  input  logic                      clk,
  input  logic [IDX_W-1:0]          rd_idx,
  input  logic [IDX_W-1:0]          wr_idx,
  input  logic [NUM_LANES-1:0]      we,
  input  logic [NUM_LANES-1:0][7:0] wdata,
  output logic [NUM_LANES-1:0][7:0] rdata
);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] mem [WORDS];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (we[i]) mem[wr_idx] <= wdata[i];
      q <= mem[rd_idx];
    end

    assign rdata[i] = q;
  end

endmodule

// File: rtl/p2_mem.sv
// Wait-stated memory slave: strobe-qualified decode, WAIT_CYCLES wait states,
// one array access per strobe, read data driven on the bus while held in HOLD.
module p2_mem
  import p2_mem_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int MEM_BYTES    = DEF_MEM_BYTES,
  parameter int DECODE_LIMIT = DEF_DECODE_LIMIT,
  parameter int WAIT_CYCLES  = DEF_WAIT_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  decode,
  input  logic                  go_n,
  input  logic                  rw_n,
  input  logic [DATA_W/8-1:0]   be_n,
  input  logic [DATA_W-1:0]     datai,
  output logic [DATA_W-1:0]     datao,
  output logic                  datao_oe,
  output logic                  wait_n
);

  localparam int NUM_LANES = DATA_W / 8;
  localparam int LANE_SH   = $clog2(NUM_LANES);
  localparam int WORDS     = MEM_BYTES / NUM_LANES;
  localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [ADDR_W:0] DEC_LIM = (ADDR_W+1)'(DECODE_LIMIT);
  localparam logic [ADDR_W:0] MEM_LIM = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [3:0]      WC_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [1:0]           state;
  logic [3:0]           cnt;
  logic [ADDR_W-1:0]    addr_q;
  logic                 rw_q;
  logic [NUM_LANES-1:0] be_q;
  logic [DATA_W-1:0]    data_q;

  logic                 hit, in_range;
  logic [IDX_W-1:0]     rd_idx, wr_idx;
  logic [NUM_LANES-1:0] we;
  logic [NUM_LANES-1:0][7:0] wdata, rdata;

  assign hit      = decode && !go_n && ({1'b0, addr} < DEC_LIM);
  assign in_range = {1'b0, addr_q} < MEM_LIM;

  // While idle the RAM tracks the live address so read data is already
  // waiting when ACCESS is reached, even with zero wait states.
  assign rd_idx = (state == ST_IDLE) ? addr[LANE_SH +: IDX_W] : addr_q[LANE_SH +: IDX_W];
  assign wr_idx = addr_q[LANE_SH +: IDX_W];
  assign wdata  = data_q;
  assign we     = (state == ST_ACCESS && !go_n && !rw_q && in_range) ? ~be_q : '0;

  assign wait_n   = !(state == ST_WAIT || state == ST_ACCESS);
  assign datao_oe = (state == ST_HOLD) && rw_q;

  p2_mem_array #(
    .NUM_LANES(NUM_LANES),
    .WORDS    (WORDS),
    .IDX_W    (IDX_W)
  ) u_array (
    .clk   (clk),
    .rd_idx(rd_idx),
    .wr_idx(wr_idx),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      datao  <= '0;
      addr_q <= '0;
      rw_q   <= 1'b1;
      be_q   <= '1;
      data_q <= '0;
    end else begin
      case (state)
        ST_IDLE: if (hit) begin
          addr_q <= addr;
          rw_q   <= rw_n;
          be_q   <= be_n;
          data_q <= datai;
          if (WAIT_CYCLES == 0) begin
            state <= ST_ACCESS;
          end else begin
            state <= ST_WAIT;
            cnt   <= WC_LOAD;
          end
        end
        ST_WAIT: begin
          if (go_n)            state <= ST_IDLE;
          else if (cnt == '0)  state <= ST_ACCESS;
          else                 cnt   <= cnt - 4'd1;
        end
        ST_ACCESS: begin
          if (go_n) begin
            state <= ST_IDLE;
          end else begin
            state <= ST_HOLD;
            if (rw_q) datao <= in_range ? rdata : '1;
          end
        end
        ST_HOLD:  if (go_n) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_p2_mem.sv
// Directed + randomized bench for p2_mem against a byte-addressed reference model.
module tb_p2_mem;

  localparam int DW = 16;
  localparam int AW = 23;
  localparam int MB = 524288;
  localparam int DL = 4194304;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] addr;
  logic          decode, go_n, rw_n;
  logic [1:0]    be_n;
  logic [DW-1:0] datai, datao;
  logic          datao_oe, wait_n;

  int n_chk = 0;
  int n_fail = 0;
  int low;
  logic tmo;
  logic [7:0] mdl [int];

  p2_mem #(
    .DATA_W(DW), .ADDR_W(AW), .MEM_BYTES(MB), .DECODE_LIMIT(DL), .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .decode(decode), .go_n(go_n),
    .rw_n(rw_n), .be_n(be_n), .datai(datai), .datao(datao),
    .datao_oe(datao_oe), .wait_n(wait_n)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mdl_read(input int a);
    logic [15:0] r;
    int base;
    base = a & ~1;
    if (a >= MB) return 16'hFFFF;
    for (int l = 0; l < 2; l++)
      r[8*l +: 8] = mdl.exists(base + l) ? mdl[base + l] : 8'hxx;
    return r;
  endfunction

  function automatic void mdl_write(input int a, input logic [1:0] be, input logic [15:0] d);
    int base;
    base = a & ~1;
    if (a >= MB) return;
    for (int l = 0; l < 2; l++)
      if (!be[l]) mdl[base + l] = d[8*l +: 8];
  endfunction

  // Drive a cycle and run until wait_n returns high after having gone low.
  task automatic start(input int a, input logic rw, input logic [1:0] be, input logic [15:0] d);
    @(posedge clk); #1;
    addr = AW'(a); rw_n = rw; be_n = be; datai = d; decode = 1'b1; go_n = 1'b0;
    low = 0; tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (!wait_n) low++;
      else if (low > 0) begin tmo = 1'b0; break; end
    end
  endtask

  task automatic release_go;
    go_n = 1'b1; decode = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic do_write(input int a, input logic [1:0] be, input logic [15:0] d, input string tag);
    start(a, 1'b0, be, d);
    chk({tag, "_tmo"}, 32'(tmo), 32'd0);
    chk({tag, "_waits"}, 32'(low), 32'(WC + 1));
    chk({tag, "_oe"}, 32'(datao_oe), 32'd0);
    release_go;
    mdl_write(a, be, d);
  endtask

  task automatic do_read(input int a, input string tag);
    start(a, 1'b1, 2'b00, 16'h0);
    chk({tag, "_tmo"}, 32'(tmo), 32'd0);
    chk({tag, "_waits"}, 32'(low), 32'(WC + 1));
    chk({tag, "_data"}, 32'(datao), 32'(mdl_read(a)));
    chk({tag, "_oe"}, 32'(datao_oe), 32'd1);
    release_go;
    chk({tag, "_oe_off"}, 32'(datao_oe), 32'd0);
  endtask

  initial begin
    int pool [8];
    int a, k;
    logic [15:0] d;

    reset_n = 1'b0; addr = '0; decode = 1'b0; go_n = 1'b1; rw_n = 1'b1;
    be_n = 2'b11; datai = '0;
    #3;
    chk("rst_wait_n", 32'(wait_n), 32'd1);
    chk("rst_oe", 32'(datao_oe), 32'd0);
    chk("rst_datao", 32'(datao), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Basic write/read
    do_write(32'h100, 2'b00, 16'hBEEF, "w100");
    do_read (32'h100, "r100");

    // Byte-lane merges and all-lanes-disabled write
    do_write(32'h200, 2'b00, 16'h1234, "w200");
    do_write(32'h200, 2'b10, 16'h00AB, "w200_lo");
    do_read (32'h200, "r200_lo");
    do_write(32'h200, 2'b01, 16'hCD00, "w200_hi");
    do_read (32'h200, "r200_hi");
    do_write(32'h200, 2'b11, 16'h5555, "w200_none");
    do_read (32'h200, "r200_none");

    // Decoded but unpopulated: reads all ones, writes dropped (would alias word 0)
    do_write(32'h0, 2'b00, 16'h7777, "w0");
    do_read (32'h100000, "r_unpop");
    do_write(32'h100000, 2'b00, 16'h0000, "w_unpop");
    do_read (32'h0, "r0_after");

    // Outside decode window, then decode deasserted: no response at all
    @(posedge clk); #1;
    addr = AW'(32'h400000); decode = 1'b1; go_n = 1'b0; rw_n = 1'b1; be_n = 2'b00;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("nodec_wait_n", 32'(wait_n), 32'd1);
      chk("nodec_oe", 32'(datao_oe), 32'd0);
    end
    addr = AW'(32'h100); decode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("desel_wait_n", 32'(wait_n), 32'd1);
    end
    release_go;
    do_read(32'h100, "r100_post");

    // Abort in WAIT
    do_write(32'h300, 2'b00, 16'h5A5A, "w300");
    @(posedge clk); #1;
    addr = AW'(32'h300); rw_n = 1'b0; be_n = 2'b00; datai = 16'h1111; decode = 1'b1; go_n = 1'b0;
    @(posedge clk); #1;
    chk("abw_in_wait", 32'(wait_n), 32'd0);
    go_n = 1'b1;
    @(posedge clk); #1;
    chk("abw_idle", 32'(wait_n), 32'd1);
    @(posedge clk); #1;
    chk("abw_idle2", 32'(wait_n), 32'd1);
    decode = 1'b0;
    do_read(32'h300, "r300");

    // Abort in ACCESS
    do_write(32'h302, 2'b00, 16'hA5A5, "w302");
    @(posedge clk); #1;
    addr = AW'(32'h302); rw_n = 1'b0; be_n = 2'b00; datai = 16'h2222; decode = 1'b1; go_n = 1'b0;
    repeat (WC + 1) @(posedge clk);
    #1;
    chk("aba_in_access", 32'(wait_n), 32'd0);
    go_n = 1'b1;
    @(posedge clk); #1;
    chk("aba_idle", 32'(wait_n), 32'd1);
    decode = 1'b0;
    do_read(32'h302, "r302");

    // Async reset during HOLD of a read
    start(32'h100, 1'b1, 2'b00, 16'h0);
    chk("rsth_tmo", 32'(tmo), 32'd0);
    chk("rsth_oe_before", 32'(datao_oe), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rsth_wait_n", 32'(wait_n), 32'd1);
    chk("rsth_oe", 32'(datao_oe), 32'd0);
    chk("rsth_datao", 32'(datao), 32'd0);
    #1 reset_n = 1'b1;
    go_n = 1'b1; decode = 1'b0;
    @(posedge clk); #1;
    do_read(32'h100, "r100_after_rst");

    // Randomized traffic over a prefilled pool plus unpopulated addresses
    for (int i = 0; i < 8; i++) begin
      pool[i] = 32'h1000 + i * 74;
      do_write(pool[i], 2'b00, 16'($urandom), "rnd_fill");
    end
    for (int i = 0; i < 24; i++) begin
      k = $urandom_range(0, 7);
      a = pool[k] | int'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) a = int'($urandom_range(MB, DL - 1));
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) do_read(a, "rnd_rd");
      else do_write(a, 2'($urandom), d, "rnd_wr");
    end
    for (int i = 0; i < 8; i++) do_read(pool[i], "rnd_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
